// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Tracks the destination of each in-flight instruction from EX up to the
// register-file write point, selects bypass data for both decode operands,
// stalls IF/ID on load-use hazards and counts stall cycles.
module fwd_hazard_unit #(
    parameter int DW         = 16,
    parameter int RW_W       = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                id_valid,
    input  logic [RW_W-1:0]     id_rs,
    input  logic [RW_W-1:0]     id_rt,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic [RW_W-1:0]     id_rw,
    input  logic                id_regwr,
    input  logic                id_memrd,
    input  logic                id_flush,
    input  logic [DW-1:0]       rf_a,
    input  logic [DW-1:0]       rf_b,
    input  logic [DEPTH*DW-1:0] stage_data,
    output logic [DW-1:0]       fwd_a,
    output logic [DW-1:0]       fwd_b,
    output logic [SEL_W-1:0]    fwd_a_sel,
    output logic [SEL_W-1:0]    fwd_b_sel,
    output logic                stall,
    output logic                ex_bubble,
    output logic [CNT_W-1:0]    stall_count
);

    // Stage k (1 = EX) holds the producer info of the instruction in that stage.
    logic [DEPTH:1]  ent_valid;
    logic [DEPTH:1]  ent_regwr;
    logic [DEPTH:1]  ent_memrd;
    logic [RW_W-1:0] ent_rw [1:DEPTH];

    logic load_a;
    logic load_b;
    logic new_valid;

    // Operand A bypass: scan oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd_a_sel = '0;
        fwd_a     = rf_a;
        load_a    = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (ent_valid[k] && ent_regwr[k] && (ent_rw[k] == id_rs) &&
                id_rs_used && id_valid) begin
                fwd_a_sel = SEL_W'(k);
                fwd_a     = stage_data[(k-1)*DW +: DW];
                load_a    = ent_memrd[k] && (k < LOAD_STAGE);
            end
        end
    end

    // Operand B bypass: same selection rule on rt.
    always_comb begin
        fwd_b_sel = '0;
        fwd_b     = rf_b;
        load_b    = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (ent_valid[k] && ent_regwr[k] && (ent_rw[k] == id_rt) &&
                id_rt_used && id_valid) begin
                fwd_b_sel = SEL_W'(k);
                fwd_b     = stage_data[(k-1)*DW +: DW];
                load_b    = ent_memrd[k] && (k < LOAD_STAGE);
            end
        end
    end

    // A load whose data is not ready yet forces the ID instruction to wait;
    // a flushed instruction is bubbled regardless.
    assign stall     = load_a | load_b;
    assign ex_bubble = stall | id_flush;
    assign new_valid = id_valid & ~stall & ~id_flush;

    // Tracker shifts one stage per clock; the last stage falls off after its RF write.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ent_valid <= '0;
            ent_regwr <= '0;
            ent_memrd <= '0;
            for (int k = 1; k <= DEPTH; k++) ent_rw[k] <= '0;
        end else begin
            ent_valid[1] <= new_valid;
            ent_regwr[1] <= id_regwr;
            ent_memrd[1] <= id_memrd;
            ent_rw[1]    <= id_rw;
            for (int k = 2; k <= DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_regwr[k] <= ent_regwr[k-1];
                ent_memrd[k] <= ent_memrd[k-1];
                ent_rw[k]    <= ent_rw[k-1];
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_fwd_hazard_unit;

    localparam int DW    = 16;
    localparam int RW_W  = 3;
    localparam int DEPTH = 3;
    localparam int LS    = 2;
    localparam int CNT_W = 4;
    localparam int SEL_W = 2;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                id_valid, id_rs_used, id_rt_used, id_regwr, id_memrd, id_flush;
    logic [RW_W-1:0]     id_rs, id_rt, id_rw;
    logic [DW-1:0]       rf_a, rf_b;
    logic [DEPTH*DW-1:0] stage_data;
    logic [DW-1:0]       fwd_a, fwd_b;
    logic [SEL_W-1:0]    fwd_a_sel, fwd_b_sel;
    logic                stall, ex_bubble;
    logic [CNT_W-1:0]    stall_count;

    int n_vec = 0;
    int n_bad = 0;

    fwd_hazard_unit #(.DW(DW), .RW_W(RW_W), .DEPTH(DEPTH), .LOAD_STAGE(LS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rw(id_rw),
        .id_regwr(id_regwr), .id_memrd(id_memrd), .id_flush(id_flush),
        .rf_a(rf_a), .rf_b(rf_b), .stage_data(stage_data),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .ex_bubble(ex_bubble), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct { bit v; bit wr; bit mr; int rw; } instr_t;
    instr_t pipe[$];          // pipe[0] = instruction in EX
    int     m_cnt;
    int     e_sel_a, e_sel_b, e_fa, e_fb;
    bit     e_stall, e_bub;

    function automatic int youngest_writer(int r, bit used);
        if (!used || !id_valid) return 0;
        foreach (pipe[i]) if (pipe[i].v && pipe[i].wr && pipe[i].rw == r) return i + 1;
        return 0;
    endfunction

    function automatic void model_eval();
        e_sel_a = youngest_writer(int'(id_rs), id_rs_used);
        e_sel_b = youngest_writer(int'(id_rt), id_rt_used);
        e_fa = (e_sel_a == 0) ? int'(rf_a) : int'(stage_data[(e_sel_a-1)*DW +: DW]);
        e_fb = (e_sel_b == 0) ? int'(rf_b) : int'(stage_data[(e_sel_b-1)*DW +: DW]);
        e_stall = (e_sel_a != 0 && e_sel_a < LS && pipe[e_sel_a-1].mr) ||
                  (e_sel_b != 0 && e_sel_b < LS && pipe[e_sel_b-1].mr);
        e_bub = e_stall || id_flush;
    endfunction

    function automatic void model_clock();
        instr_t n;
        model_eval();
        if (!RST_N) begin
            pipe.delete();
            for (int i = 0; i < DEPTH; i++) pipe.push_back('{0, 0, 0, 0});
            m_cnt = 0;
        end else begin
            n.v = id_valid && !e_stall && !id_flush;
            n.wr = id_regwr; n.mr = id_memrd; n.rw = int'(id_rw);
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (e_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic set_id(bit v, int rs, bit rsu, int rt, bit rtu, int rw, bit wr, bit mr, bit fl);
        id_valid = v; id_rs = RW_W'(rs); id_rs_used = rsu; id_rt = RW_W'(rt);
        id_rt_used = rtu; id_rw = RW_W'(rw); id_regwr = wr; id_memrd = mr; id_flush = fl;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        RST_N = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rf_a = 16'h1234; rf_b = 16'h5678;
        stage_data = {16'h0003, 16'h0002, 16'h0005};
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 1, 0, 0);          // ADD R1,R1,R2
        #1;
        n_vec++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin n_bad++;
            $display("FAIL reset_sel: got a=%0d b=%0d want 0/0", fwd_a_sel, fwd_b_sel); end
        n_vec++; if (stall_count !== 4'd0 || stall !== 1'b0 || ex_bubble !== 1'b0) begin n_bad++;
            $display("FAIL reset_ctl: got cnt=%0d stall=%b bub=%b want 0/0/0", stall_count, stall, ex_bubble); end
        n_vec++; if (fwd_a !== 16'h1234 || fwd_b !== 16'h5678) begin n_bad++;
            $display("FAIL reset_rf: got %h/%h want 1234/5678", fwd_a, fwd_b); end
        tick();
        set_id(1, 1, 1, 4, 1, 3, 1, 0, 0);          // SUB R3,R1,R4
        #1;
        n_vec++; if (fwd_a_sel !== 2'd1 || fwd_a !== 16'h0005 || stall !== 1'b0) begin n_bad++;
            $display("FAIL b2b_fwd: got sel=%0d fwd=%h stall=%b want 1/0005/0", fwd_a_sel, fwd_a, stall); end
        n_vec++; if (fwd_b_sel !== 2'd0 || fwd_b !== 16'h5678) begin n_bad++;
            $display("FAIL b2b_nofwd_b: got sel=%0d fwd=%h want 0/5678", fwd_b_sel, fwd_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        stage_data = {16'h0000, 16'hBEEF, 16'h0000};
        set_id(1, 0, 0, 0, 0, 2, 1, 1, 0);          // LW R2
        tick();
        set_id(1, 2, 1, 4, 1, 3, 1, 0, 0);          // ADD R3,R2,R4
        #1;
        n_vec++; if (stall !== 1'b1 || ex_bubble !== 1'b1 || fwd_a_sel !== 2'd1) begin n_bad++;
            $display("FAIL lu_stall: got stall=%b bub=%b sel=%0d want 1/1/1", stall, ex_bubble, fwd_a_sel); end
        tick();
        #1;
        n_vec++; if (stall !== 1'b0 || ex_bubble !== 1'b0) begin n_bad++;
            $display("FAIL lu_release: got stall=%b bub=%b want 0/0", stall, ex_bubble); end
        n_vec++; if (fwd_a_sel !== 2'd2 || fwd_a !== 16'hBEEF || stall_count !== 4'd1) begin n_bad++;
            $display("FAIL lu_fwd: got sel=%0d fwd=%h cnt=%0d want 2/beef/1", fwd_a_sel, fwd_a, stall_count); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        #1;
        n_vec++; if (stall_count !== 4'd1) begin n_bad++;
            $display("FAIL lu_count_hold: got %0d want 1", stall_count); end
    endtask

    task automatic test_priority();
        do_reset();
        rf_b = 16'h7777;
        stage_data = {16'h0033, 16'h0022, 16'h0011};
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();  // older writer of R5
        set_id(1, 0, 0, 0, 0, 6, 0, 0, 0); tick();  // non-writer
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();  // younger writer of R5
        set_id(1, 0, 0, 5, 1, 7, 1, 0, 0);
        #1;
        n_vec++; if (fwd_b_sel !== 2'd1 || fwd_b !== 16'h0011) begin n_bad++;
            $display("FAIL prio: got sel=%0d fwd=%h want 1/0011", fwd_b_sel, fwd_b); end
        set_id(1, 0, 0, 5, 0, 7, 1, 0, 0);          // rt not used
        #1;
        n_vec++; if (fwd_b_sel !== 2'd0 || fwd_b !== 16'h7777) begin n_bad++;
            $display("FAIL prio_unused: got sel=%0d fwd=%h want 0/7777", fwd_b_sel, fwd_b); end
    endtask

    task automatic test_flush();
        do_reset();
        rf_a = 16'hAAAA;
        stage_data = {16'h0003, 16'h0002, 16'h0666};
        set_id(1, 0, 0, 0, 0, 6, 1, 0, 1);          // flushed writer of R6
        #1;
        n_vec++; if (ex_bubble !== 1'b1 || stall !== 1'b0) begin n_bad++;
            $display("FAIL flush_bub: got bub=%b stall=%b want 1/0", ex_bubble, stall); end
        tick();
        set_id(1, 6, 1, 0, 0, 1, 1, 0, 0);
        #1;
        n_vec++; if (fwd_a_sel !== 2'd0 || fwd_a !== 16'hAAAA || ex_bubble !== 1'b0) begin n_bad++;
            $display("FAIL flush_nofwd: got sel=%0d fwd=%h bub=%b want 0/aaaa/0", fwd_a_sel, fwd_a, ex_bubble); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_id(1, 0, 0, 0, 0, 2, 1, 1, 0); tick();   // LW R2
            set_id(1, 2, 1, 0, 0, 3, 1, 0, 0); tick();   // stalled use
            tick();                                      // released use
            #1;
            n_vec++; if (int'(stall_count) != ((i + 1 > 15) ? 15 : i + 1)) begin n_bad++;
                $display("FAIL sat_step%0d: got %0d want %0d", i, stall_count, (i + 1 > 15) ? 15 : i + 1); end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 0, 0, 0, 0, 2, 1, 1, 0); tick();
        set_id(1, 2, 1, 2, 1, 3, 1, 0, 0);
        #1;
        n_vec++; if (stall !== 1'b1) begin n_bad++;
            $display("FAIL rms_pre: got stall=%b want 1", stall); end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        #1;
        n_vec++; if (stall !== 1'b0 || fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || stall_count !== 4'd0) begin n_bad++;
            $display("FAIL rms_post: got stall=%b sa=%0d sb=%0d cnt=%0d want 0/0/0/0",
                     stall, fwd_a_sel, fwd_b_sel, stall_count); end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            RST_N = ($urandom_range(0, 59) != 0);
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            rf_a = DW'($urandom); rf_b = DW'($urandom);
            stage_data = {DW'($urandom), DW'($urandom), DW'($urandom)};
            #2;
            model_eval();
            n_vec++;
            if (int'(fwd_a_sel) != e_sel_a || int'(fwd_b_sel) != e_sel_b ||
                int'(fwd_a) != e_fa || int'(fwd_b) != e_fb ||
                stall !== e_stall || ex_bubble !== e_bub || int'(stall_count) != m_cnt) begin
                n_bad++;
                $display("FAIL rand%0d: got sa=%0d sb=%0d fa=%h fb=%h st=%b bu=%b cnt=%0d want sa=%0d sb=%0d fa=%h fb=%h st=%b bu=%b cnt=%0d",
                         c, fwd_a_sel, fwd_b_sel, fwd_a, fwd_b, stall, ex_bubble, stall_count,
                         e_sel_a, e_sel_b, e_fa[15:0], e_fb[15:0], e_stall, e_bub, m_cnt);
            end
            tick();
        end
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        rf_a = '0; rf_b = '0; stage_data = '0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) pipe.push_back('{0, 0, 0, 0});
        test_reset();
        test_load_use();
        test_priority();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage pipelined datapath. It is the successor to the no-forwarding build.
- Tracks the destination register of every in-flight instruction from EX up to the register-file write point.
- Selects bypass data for both decode-stage source operands.
- Stalls IF/ID on load-use hazards and bubbles the slot entering EX.
- Counts stall cycles.
- Sits beside Decode / Register_File; its outputs drive the BusA/BusB operand muxes and the PC / IF-ID hold enables.

Parameters:
- DW, 16, data width of operands and forwarded results
- RW_W, 3, register address width
- DEPTH, 3, number of tracked stages after ID (1=EX … DEPTH=last stage before RF write)
- LOAD_STAGE, 2, first stage index whose result is valid for a load (MemRd) instruction
- CNT_W, 16, stall counter width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  RW_W  source A register
- id_rt  in  RW_W  source B register
- id_rs_used  in  1  instruction reads rs
- id_rt_used  in  1  instruction reads rt
- id_rw  in  RW_W  destination register
- id_regwr  in  1  instruction writes RW
- id_memrd  in  1  instruction is a load
- id_flush  in  1  taken jump/branch/loop: kill the ID instruction
- rf_a  in  DW  register-file BusA
- rf_b  in  DW  register-file BusB
- stage_data  in  DEPTH*DW  result carried by stage k in slice [k*DW-1:(k-1)*DW]
- fwd_a  out  DW  operand A after bypass
- fwd_b  out  DW  operand B after bypass
- fwd_a_sel  out  clog2(DEPTH+1)  0=RF, k=stage k
- fwd_b_sel  out  clog2(DEPTH+1)  0=RF, k=stage k
- stall  out  1  hold PC and IF/ID this cycle
- ex_bubble  out  1  instruction entering EX is squashed
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- State: per-stage entry {valid, rw, regwr, memrd}, k=1..DEPTH, advancing one stage per clock. Entry DEPTH is discarded on the next edge.
- New stage-1 entry: the ID fields with valid = id_valid & ~stall & ~id_flush.
- Reset (RST_N=0 at an edge): all entries invalid, stall_count=0. With all entries invalid, outputs are stall=0, ex_bubble=0, fwd_*_sel=0, fwd_a=rf_a, fwd_b=rf_b.
- Reset mid-operation: the tracker is cleared at that edge. No forward or stall is derived from pre-reset entries.
- Match for source A at stage k: entry k valid & regwr & rw==id_rs & id_rs_used & id_valid. Source B uses the same rule with rt.
- Priority: the lowest matching k (youngest producer) wins. fwd_*_sel = k and fwd_* = stage_data slice k. With no match, sel=0 and the RF value is used.
- Stall: asserted if the winning match for A or B is a load (memrd=1) with k < LOAD_STAGE. stall is combinational from the current entries and ID inputs.
- While stalled, fwd_* outputs remain computed but the consumer ignores them.
- ex_bubble = stall | id_flush.
- During a stall the ID instruction is presented again next cycle and the tracker keeps advancing, so the load moves toward LOAD_STAGE. With LOAD_STAGE=2 exactly one stall cycle is inserted. In general the stall lasts LOAD_STAGE-k cycles.
- Simultaneous flush and hazard: flush dominates the entry (bubble). stall is still driven, and the counter counts the stall cycle.
- RF write occurs at the end of stage DEPTH, so stage DEPTH forwarding covers a same-cycle write. No write-read hazard exists beyond DEPTH.
- stall_count: increments by 1 at each edge with stall=1 and RST_N=1. It saturates at all-ones and does not wrap.
- Latency: forwarding and stall are zero-cycle combinational. Tracker update takes 1 cycle.

Test Plan:
- Reset: hold RST_N=0 two cycles, then ADD R1 and SUB using R1 back-to-back → after reset first cycle sel=0, stall_count=0. Next cycle fwd_a_sel=1, fwd_a=stage_data[15:0] (e.g. 16'h0005), stall=0.
- Load-use, DEPTH=3, LOAD_STAGE=2: LW R2 then ADD R3,R2,R4 → stall=1 and ex_bubble=1 for exactly 1 cycle. Then fwd_a_sel=2, fwd_a=load data 16'hBEEF, stall_count=1.
- Priority: R5 written by instructions in stages 1 and 3, both values (16'h0011 / 16'h0033) presented → fwd_b_sel=1, fwd_b=16'h0011.
- Flush: id_flush=1 with ID instruction writing R6, next instruction reads R6 → stage-1 entry invalid, no forward (sel=0, fwd=rf value), ex_bubble=1.
- Saturation, CNT_W=4: force 20 consecutive load-use stalls → stall_count reaches 4'hF and holds.
- Reset mid-stall: assert RST_N=0 during a load-use stall → next cycle stall=0, all sel=0, stall_count=0.
